alarm_ring: RTL and testbench

Alarm detection and ringing controller, the consumer of the alarm-time setting registers. Compares the running BCD clock time against the stored BCD alarm hour/minute, and on a match at second 00 drives a ringing state with an on/off buzzer pattern, a stop button and a snooze button. Sits between the time counters / alarm-setting counters and the buzzer/LED outputs of the digital clock.

---
 rtl/clock_pkg.sv | 22 ++
 rtl/btn_edge.sv | 22 ++
 rtl/alarm_ring.sv | 167 ++++++++++++++++
 tb/tb_alarm_ring.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared clock/alarm types: alarm FSM state encoding and BCD digit width.
// Pure declarations, no timing or flow control involved.
package clock_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2
    } alarm_state_t;

    function automatic logic bcd_pair_eq(
        input logic [BCD_W-1:0] a_tens,
        input logic [BCD_W-1:0] a_ones,
        input logic [BCD_W-1:0] b_tens,
        input logic [BCD_W-1:0] b_ones
    );
        return (a_tens == b_tens) && (a_ones == b_ones);
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Single-register rising-edge detector; o_rise is combinational on i_lvl.
// One cycle of history, no flow control.
module btn_edge (
    input  logic clk,
    input  logic CLR_n,
    input  logic i_lvl,
    output logic o_rise
);

    logic r_lvl_q;

    always_ff @(posedge clk or negedge CLR_n) begin
        if (!CLR_n) begin
            r_lvl_q <= 1'b0;
        end else begin
            r_lvl_q <= i_lvl;
        end
    end

    assign o_rise = i_lvl & ~r_lvl_q;

endmodule

// File: rtl/alarm_ring.sv
// Alarm match detection and IDLE/RING/SNOOZE ringing controller with buzzer pattern.
// Outputs are registered from next-state values (one edge after the causing input); no backpressure.
module alarm_ring
    import clock_pkg::*;
#(
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_SECONDS = 300
) (
    input  logic             clk,
    input  logic             CLR_n,
    input  logic             sec_tick,
    input  logic             alarm_en,
    input  logic             isSettingAlarm,
    input  logic [BCD_W-1:0] cur_hour_tens,
    input  logic [BCD_W-1:0] cur_hour_ones,
    input  logic [BCD_W-1:0] cur_minute_tens,
    input  logic [BCD_W-1:0] cur_minute_ones,
    input  logic [BCD_W-1:0] cur_second_tens,
    input  logic [BCD_W-1:0] cur_second_ones,
    input  logic [BCD_W-1:0] alarm_hour_tens,
    input  logic [BCD_W-1:0] alarm_hour_ones,
    input  logic [BCD_W-1:0] alarm_minute_tens,
    input  logic [BCD_W-1:0] alarm_minute_ones,
    input  logic             stop_btn,
    input  logic             snooze_btn,
    output logic             ringing,
    output logic             buzzer,
    output logic             snoozed
);

    localparam int RW = $clog2(RING_SECONDS + 1);
    localparam int SW = $clog2(SNOOZE_SECONDS + 1);
    localparam logic [RW-1:0] RING_TERM   = RW'(RING_SECONDS);
    localparam logic [SW-1:0] SNOOZE_TERM = SW'(SNOOZE_SECONDS);

    alarm_state_t  r_state;
    alarm_state_t  w_state_nxt;
    logic [RW-1:0] r_ring_cnt;
    logic [RW-1:0] w_ring_cnt_nxt;
    logic [RW-1:0] w_ring_inc;
    logic [SW-1:0] r_snooze_cnt;
    logic [SW-1:0] w_snooze_cnt_nxt;
    logic [SW-1:0] w_snooze_inc;
    logic          r_beep_phase;
    logic          w_beep_nxt;
    logic          r_ringing;
    logic          r_buzzer;
    logic          r_snoozed;
    logic          w_ringing_nxt;
    logic          w_buzzer_nxt;
    logic          w_snoozed_nxt;
    logic          w_match;
    logic          w_trigger;
    logic          w_stop_rise;
    logic          w_snooze_rise;
    logic          w_disarm;

    // Alarm fires only at second 00 of the matching minute, and only when armed and not being edited.
    assign w_match = bcd_pair_eq(cur_hour_tens, cur_hour_ones, alarm_hour_tens, alarm_hour_ones)
                   && bcd_pair_eq(cur_minute_tens, cur_minute_ones, alarm_minute_tens, alarm_minute_ones)
                   && (cur_second_tens == '0) && (cur_second_ones == '0)
                   && alarm_en && !isSettingAlarm;

    assign w_disarm     = isSettingAlarm || !alarm_en;
    assign w_ring_inc   = r_ring_cnt + RW'(1);
    assign w_snooze_inc = r_snooze_cnt + SW'(1);

    btn_edge u_match_edge (
        .clk    (clk),
        .CLR_n  (CLR_n),
        .i_lvl  (w_match),
        .o_rise (w_trigger)
    );

    btn_edge u_stop_edge (
        .clk    (clk),
        .CLR_n  (CLR_n),
        .i_lvl  (stop_btn),
        .o_rise (w_stop_rise)
    );

    btn_edge u_snooze_edge (
        .clk    (clk),
        .CLR_n  (CLR_n),
        .i_lvl  (snooze_btn),
        .o_rise (w_snooze_rise)
    );

    always_ff @(posedge clk or negedge CLR_n) begin
        if (!CLR_n) begin
            r_state      <= ST_IDLE;
            r_ring_cnt   <= '0;
            r_snooze_cnt <= '0;
            r_beep_phase <= 1'b0;
            r_ringing    <= 1'b0;
            r_buzzer     <= 1'b0;
            r_snoozed    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ring_cnt   <= w_ring_cnt_nxt;
            r_snooze_cnt <= w_snooze_cnt_nxt;
            r_beep_phase <= w_beep_nxt;
            r_ringing    <= w_ringing_nxt;
            r_buzzer     <= w_buzzer_nxt;
            r_snoozed    <= w_snoozed_nxt;
        end
    end

    // Button edges pre-empt the state's own transition, so a coincident sec_tick is dropped.
    always_comb begin
        w_state_nxt      = r_state;
        w_ring_cnt_nxt   = r_ring_cnt;
        w_snooze_cnt_nxt = r_snooze_cnt;
        w_beep_nxt       = r_beep_phase;
        if (w_disarm) begin
            w_state_nxt = ST_IDLE;
        end else if (w_stop_rise && (r_state != ST_IDLE)) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_trigger) begin
                        w_state_nxt    = ST_RING;
                        w_ring_cnt_nxt = '0;
                        w_beep_nxt     = 1'b1;
                    end
                end
                ST_RING: begin
                    if (w_snooze_rise) begin
                        w_state_nxt      = ST_SNOOZE;
                        w_snooze_cnt_nxt = '0;
                    end else if (sec_tick) begin
                        w_ring_cnt_nxt = w_ring_inc;
                        w_beep_nxt     = ~r_beep_phase;
                        if (w_ring_inc == RING_TERM) begin
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end
                ST_SNOOZE: begin
                    if (sec_tick) begin
                        w_snooze_cnt_nxt = w_snooze_inc;
                        if (w_snooze_inc == SNOOZE_TERM) begin
                            w_state_nxt    = ST_RING;
                            w_ring_cnt_nxt = '0;
                            w_beep_nxt     = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_ringing_nxt = (w_state_nxt == ST_RING);
        w_snoozed_nxt = (w_state_nxt == ST_SNOOZE);
        w_buzzer_nxt  = (w_state_nxt == ST_RING) && w_beep_nxt;
    end

    assign ringing = r_ringing;
    assign buzzer  = r_buzzer;
    assign snoozed = r_snoozed;

endmodule

// File: tb/tb_alarm_ring.sv
// Directed bench for alarm_ring with RING_SECONDS=5, SNOOZE_SECONDS=3; alarm set to 07:30.
module tb_alarm_ring;

    logic       clk;
    logic       CLR_n;
    logic       sec_tick;
    logic       alarm_en;
    logic       isSettingAlarm;
    logic [3:0] cur_hour_tens, cur_hour_ones, cur_minute_tens, cur_minute_ones;
    logic [3:0] cur_second_tens, cur_second_ones;
    logic [3:0] alarm_hour_tens, alarm_hour_ones, alarm_minute_tens, alarm_minute_ones;
    logic       stop_btn;
    logic       snooze_btn;
    logic       ringing;
    logic       buzzer;
    logic       snoozed;

    int n_checks = 0;
    int n_errors = 0;

    alarm_ring #(.RING_SECONDS(5), .SNOOZE_SECONDS(3)) dut (
        .clk               (clk),
        .CLR_n             (CLR_n),
        .sec_tick          (sec_tick),
        .alarm_en          (alarm_en),
        .isSettingAlarm    (isSettingAlarm),
        .cur_hour_tens     (cur_hour_tens),
        .cur_hour_ones     (cur_hour_ones),
        .cur_minute_tens   (cur_minute_tens),
        .cur_minute_ones   (cur_minute_ones),
        .cur_second_tens   (cur_second_tens),
        .cur_second_ones   (cur_second_ones),
        .alarm_hour_tens   (alarm_hour_tens),
        .alarm_hour_ones   (alarm_hour_ones),
        .alarm_minute_tens (alarm_minute_tens),
        .alarm_minute_ones (alarm_minute_ones),
        .stop_btn          (stop_btn),
        .snooze_btn        (snooze_btn),
        .ringing           (ringing),
        .buzzer            (buzzer),
        .snoozed           (snoozed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge, outputs are sampled there too.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sec();
        sec_tick = 1'b1;
        step(1);
        sec_tick = 1'b0;
    endtask

    task automatic set_time(input logic [3:0] ht, ho, mt, mo, st, so);
        cur_hour_tens   = ht;
        cur_hour_ones   = ho;
        cur_minute_tens = mt;
        cur_minute_ones = mo;
        cur_second_tens = st;
        cur_second_ones = so;
    endtask

    task automatic outs(input string tag, input logic r, input logic b, input logic s);
        chk({tag, ".ringing"}, 32'(ringing), 32'(r));
        chk({tag, ".buzzer"},  32'(buzzer),  32'(b));
        chk({tag, ".snoozed"}, 32'(snoozed), 32'(s));
    endtask

    // Step from 07:29:59 into 07:30:00 so the match rises.
    task automatic start_ring(input string tag);
        set_time(0, 7, 2, 9, 5, 9);
        step(1);
        set_time(0, 7, 3, 0, 0, 0);
        step(1);
        outs(tag, 1, 1, 0);
    endtask

    task automatic leave_minute();
        set_time(0, 7, 3, 0, 0, 1);
        step(1);
    endtask

    initial begin
        CLR_n = 1'b0;
        sec_tick = 1'b0;
        alarm_en = 1'b1;
        isSettingAlarm = 1'b0;
        stop_btn = 1'b0;
        snooze_btn = 1'b0;
        alarm_hour_tens = 4'd0;
        alarm_hour_ones = 4'd7;
        alarm_minute_tens = 4'd3;
        alarm_minute_ones = 4'd0;
        set_time(0, 7, 2, 9, 5, 9);
        #12;
        outs("reset", 0, 0, 0);
        step(1);
        CLR_n = 1'b1;
        step(2);
        outs("idle", 0, 0, 0);

        // Ring with auto-stop after 5 ticks, buzzer 1,0,1,0,1.
        start_ring("ring_start");
        for (int k = 1; k <= 4; k++) begin
            sec();
            chk($sformatf("ring_buz_%0d", k), 32'(buzzer), 32'((k % 2) == 0));
            chk($sformatf("ring_on_%0d", k), 32'(ringing), 32'd1);
        end
        sec();
        outs("auto_stop", 0, 0, 0);
        step(3);
        chk("no_retrigger_auto", 32'(ringing), 32'd0);
        leave_minute();

        // Stop during second 00, no retrigger while the second persists.
        start_ring("stop_start");
        stop_btn = 1'b1;
        step(1);
        outs("stop", 0, 0, 0);
        step(3);
        stop_btn = 1'b0;
        step(2);
        chk("no_retrigger_stop", 32'(ringing), 32'd0);
        leave_minute();

        // Snooze with a coincident tick that must not be counted.
        start_ring("snz_start");
        sec();
        chk("snz_buz_off", 32'(buzzer), 32'd0);
        snooze_btn = 1'b1;
        sec_tick = 1'b1;
        step(1);
        sec_tick = 1'b0;
        outs("snz_enter", 0, 0, 1);
        snooze_btn = 1'b0;
        set_time(0, 7, 3, 0, 0, 1);
        sec();
        sec();
        outs("snz_wait", 0, 0, 1);
        sec();
        outs("snz_rering", 1, 1, 0);
        stop_btn = 1'b1;
        step(1);
        outs("snz_stop", 0, 0, 0);
        stop_btn = 1'b0;
        step(1);

        // Stop and snooze together: stop wins.
        start_ring("both_start");
        stop_btn = 1'b1;
        snooze_btn = 1'b1;
        step(1);
        outs("both", 0, 0, 0);
        step(1);
        chk("both_hold_snoozed", 32'(snoozed), 32'd0);
        stop_btn = 1'b0;
        snooze_btn = 1'b0;
        leave_minute();

        // Editing alarm time suppresses the ring.
        isSettingAlarm = 1'b1;
        set_time(0, 7, 2, 9, 5, 9);
        step(1);
        set_time(0, 7, 3, 0, 0, 0);
        step(2);
        chk("setting_no_ring", 32'(ringing), 32'd0);
        leave_minute();
        isSettingAlarm = 1'b0;

        // Disarmed alarm does not ring.
        alarm_en = 1'b0;
        set_time(0, 7, 3, 0, 0, 0);
        step(2);
        chk("disarmed_no_ring", 32'(ringing), 32'd0);
        leave_minute();
        alarm_en = 1'b1;

        // Wrong minute / wrong hour do not ring.
        set_time(0, 7, 3, 1, 0, 0);
        step(2);
        chk("wrong_minute", 32'(ringing), 32'd0);
        set_time(1, 7, 3, 0, 0, 0);
        step(2);
        chk("wrong_hour", 32'(ringing), 32'd0);

        // Disarm mid-ring.
        start_ring("dis_start");
        alarm_en = 1'b0;
        step(1);
        outs("dis_mid", 0, 0, 0);
        alarm_en = 1'b1;
        leave_minute();

        // Async reset mid-snooze; snooze does not resume afterwards.
        start_ring("rst_start");
        snooze_btn = 1'b1;
        step(1);
        chk("rst_snoozed", 32'(snoozed), 32'd1);
        snooze_btn = 1'b0;
        set_time(0, 7, 3, 0, 0, 1);
        #2;
        CLR_n = 1'b0;
        #1;
        outs("rst_async", 0, 0, 0);
        step(1);
        CLR_n = 1'b1;
        step(1);
        for (int k = 0; k < 4; k++) sec();
        outs("rst_after", 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
